// File: rtl/cap_pkg.sv
// Shared types and defaults for the cellular-automaton program sequencer.
// Holds the FSM state encoding, the END opcode and the default widths.
package cap_pkg;

  localparam int PC_W_DEF    = 12;
  localparam int INSTR_W_DEF = 16;
  localparam int GEN_W_DEF   = 32;

  localparam logic [3:0] OPC_END = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_DONE,
    S_WAIT_SYNC
  } state_t;

  function automatic logic is_end(input logic [3:0] opc);
    return opc == OPC_END;
  endfunction

endpackage

// File: rtl/program_memory.sv
// Program store: synchronous 1R1W RAM, one-cycle read latency, no reset.
// A read and write to the same address in one cycle returns the old word.
module program_memory #(
  parameter int AW = 12,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/program_sequencer.sv
// Broadcast sequencer: replays the stored cell program once per generation,
// optionally gated on frame sync, and counts completed generations.
module program_sequencer
  import cap_pkg::*;
#(
  parameter int PC_WIDTH    = PC_W_DEF,
  parameter int INSTR_WIDTH = INSTR_W_DEF,
  parameter int GEN_WIDTH   = GEN_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   prog_we,
  input  logic [PC_WIDTH-1:0]    prog_addr,
  input  logic [INSTR_WIDTH-1:0] prog_wdata,
  input  logic                   start,
  input  logic                   step,
  input  logic                   stop,
  input  logic                   sync_enable,
  input  logic                   frame_sync,
  output logic [PC_WIDTH-1:0]    program_counter,
  output logic [INSTR_WIDTH-1:0] instruction,
  output logic                   execution_enable,
  output logic                   busy,
  output logic                   gen_done,
  output logic [GEN_WIDTH-1:0]   gen_count
);

  localparam logic [PC_WIDTH-1:0] PC_MAX = '1;

  state_t                 r_state;
  logic [PC_WIDTH-1:0]    r_pc;
  logic                   r_run;
  logic                   r_stop;
  logic                   r_sync_pending;
  logic                   r_last;
  logic [PC_WIDTH-1:0]    r_pc_out;
  logic [INSTR_WIDTH-1:0] r_instr;
  logic                   r_exec_en;
  logic                   r_gen_done;
  logic [GEN_WIDTH-1:0]   r_gen_count;

  logic                   w_we;
  logic [PC_WIDTH-1:0]    w_raddr;
  logic [INSTR_WIDTH-1:0] w_rdata;
  logic                   w_is_end;

  assign w_we     = prog_we && (r_state == S_IDLE);
  assign w_is_end = is_end(w_rdata[INSTR_WIDTH-1 -: 4]);

  // r_pc tracks the address whose word is on the RAM output
  always_comb begin
    w_raddr = '0;
    if (r_state == S_EXEC) w_raddr = r_pc + 1'b1;
  end

  program_memory #(
    .AW(PC_WIDTH),
    .DW(INSTR_WIDTH)
  ) u_mem (
    .clk    (clk),
    .i_we   (w_we),
    .i_waddr(prog_addr),
    .i_wdata(prog_wdata),
    .i_raddr(w_raddr),
    .o_rdata(w_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_pc           <= '0;
      r_run          <= 1'b0;
      r_stop         <= 1'b0;
      r_sync_pending <= 1'b0;
      r_last         <= 1'b0;
      r_pc_out       <= '0;
      r_instr        <= '0;
      r_exec_en      <= 1'b0;
      r_gen_done     <= 1'b0;
      r_gen_count    <= '0;
    end else begin
      r_exec_en  <= 1'b0;
      r_gen_done <= 1'b0;
      if (frame_sync && r_state != S_WAIT_SYNC)
        r_sync_pending <= 1'b1;
      unique case (r_state)
        S_IDLE: begin
          r_stop <= 1'b0;
          if (start) begin
            if (!stop) begin
              r_run   <= 1'b1;
              r_state <= S_FETCH;
            end
          end else if (step) begin
            r_run   <= 1'b0;
            r_state <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (stop) r_stop <= 1'b1;
          r_pc    <= '0;
          r_last  <= 1'b0;
          r_state <= S_EXEC;
        end
        S_EXEC: begin
          if (stop) r_stop <= 1'b1;
          if (w_is_end || r_last) begin
            r_gen_done  <= 1'b1;
            r_gen_count <= r_gen_count + 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_exec_en <= 1'b1;
            r_pc_out  <= r_pc;
            r_instr   <= w_rdata;
            r_pc      <= r_pc + 1'b1;
            r_last    <= (r_pc == PC_MAX);
          end
        end
        S_DONE: begin
          if (!r_run || r_stop || stop) r_state <= S_IDLE;
          else if (sync_enable)         r_state <= S_WAIT_SYNC;
          else                          r_state <= S_FETCH;
        end
        S_WAIT_SYNC: begin
          if (frame_sync || r_sync_pending) begin
            r_sync_pending <= 1'b0;
            r_state        <= S_FETCH;
          end else if (stop) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign program_counter  = r_pc_out;
  assign instruction      = r_instr;
  assign execution_enable = r_exec_en;
  assign busy             = (r_state != S_IDLE);
  assign gen_done         = r_gen_done;
  assign gen_count        = r_gen_count;

endmodule

// File: tb/tb_program_sequencer.sv
// Directed bench for program_sequencer with a broadcast scoreboard.
// Expected (pc, word) pairs are queued at load time and popped on each enable.
module tb_program_sequencer;

  localparam int PCW = 12;
  localparam int IW  = 16;
  localparam int GW  = 32;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           prog_we = 1'b0;
  logic [PCW-1:0] prog_addr = '0;
  logic [IW-1:0]  prog_wdata = '0;
  logic           start = 1'b0;
  logic           step = 1'b0;
  logic           stop = 1'b0;
  logic           sync_enable = 1'b0;
  logic           frame_sync = 1'b0;
  logic [PCW-1:0] program_counter;
  logic [IW-1:0]  instruction;
  logic           execution_enable;
  logic           busy;
  logic           gen_done;
  logic [GW-1:0]  gen_count;

  always #5 clk = ~clk;

  program_sequencer #(
    .PC_WIDTH(PCW),
    .INSTR_WIDTH(IW),
    .GEN_WIDTH(GW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .prog_we         (prog_we),
    .prog_addr       (prog_addr),
    .prog_wdata      (prog_wdata),
    .start           (start),
    .step            (step),
    .stop            (stop),
    .sync_enable     (sync_enable),
    .frame_sync      (frame_sync),
    .program_counter (program_counter),
    .instruction     (instruction),
    .execution_enable(execution_enable),
    .busy            (busy),
    .gen_done        (gen_done),
    .gen_count       (gen_count)
  );

  int checks = 0;
  int errors = 0;
  logic [PCW+IW-1:0] sb[$];
  int gaps[$];
  int en_cnt = 0;
  int gd_cnt = 0;
  int lowcnt = 0;
  logic prev_en = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (execution_enable) begin
        en_cnt++;
        if (!prev_en) gaps.push_back(lowcnt);
        lowcnt = 0;
        chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0)
          chk("bcast", 64'({program_counter, instruction}),
              64'(sb.pop_front()));
      end else begin
        lowcnt++;
      end
      if (gen_done) begin
        gd_cnt++;
        chk("gd_excl", 64'(execution_enable), 64'd0);
      end
      prev_en = execution_enable;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic wr(input int a, input logic [IW-1:0] d);
    prog_we    = 1'b1;
    prog_addr  = PCW'(a);
    prog_wdata = d;
    @(negedge clk);
    prog_we    = 1'b0;
  endtask

  task automatic push(input int a, input logic [IW-1:0] d);
    sb.push_back({PCW'(a), d});
  endtask

  task automatic pulse_step();
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int maxc);
    int n = 0;
    while (busy && n < maxc) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 64'(busy), 64'd0);
  endtask

  task automatic wait_en(input string tag, input int maxc);
    int n = 0;
    while (!execution_enable && n < maxc) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 64'(execution_enable), 64'd1);
  endtask

  task automatic wait_gd(input string tag, input int tgt, input int maxc);
    int n = 0;
    while (gd_cnt < tgt && n < maxc) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 64'(gd_cnt >= tgt), 64'd1);
  endtask

  initial begin
    int e0, g0, exp_gc, n;
    exp_gc = 0;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_pc",    64'(program_counter),  64'd0);
    chk("rst_instr", 64'(instruction),      64'd0);
    chk("rst_en",    64'(execution_enable), 64'd0);
    chk("rst_busy",  64'(busy),             64'd0);
    chk("rst_gd",    64'(gen_done),         64'd0);
    chk("rst_gc",    64'(gen_count),        64'd0);
    rst = 1'b0;
    @(negedge clk);

    // basic run: 3 words + END, single step
    wr(0, 16'h1111); wr(1, 16'h2222); wr(2, 16'h3333); wr(3, 16'hF000);
    push(0, 16'h1111); push(1, 16'h2222); push(2, 16'h3333);
    e0 = en_cnt; g0 = gd_cnt;
    pulse_step();
    chk("t1_busy", 64'(busy), 64'd1);
    @(negedge clk);
    chk("t1_lat_en0", 64'(execution_enable), 64'd0);
    @(negedge clk);
    chk("t1_lat_pc0", 64'({execution_enable, program_counter}),
        64'({1'b1, 12'd0}));
    repeat (2) @(negedge clk);
    @(negedge clk);
    chk("t1_gd_slot", 64'({gen_done, execution_enable}), 64'b10);
    wait_idle("t1_idle", 20);
    exp_gc++;
    chk("t1_en_n", 64'(en_cnt - e0), 64'd3);
    chk("t1_gd_n", 64'(gd_cnt - g0), 64'd1);
    chk("t1_gc",   64'(gen_count), 64'(exp_gc));
    chk("t1_sb",   64'(sb.size()), 64'd0);

    // empty program
    wr(0, 16'hF000);
    e0 = en_cnt; g0 = gd_cnt;
    pulse_step();
    wait_idle("t2_idle", 20);
    exp_gc++;
    chk("t2_en_n", 64'(en_cnt - e0), 64'd0);
    chk("t2_gd_n", 64'(gd_cnt - g0), 64'd1);
    chk("t2_gc",   64'(gen_count), 64'(exp_gc));

    // continuous run, stop during generation 3
    wr(0, 16'hA001); wr(1, 16'hA002); wr(2, 16'hF000);
    for (int g = 0; g < 3; g++) begin
      push(0, 16'hA001); push(1, 16'hA002);
    end
    gaps.delete();
    e0 = en_cnt; g0 = gd_cnt;
    sync_enable = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_gd("t3_gd2", g0 + 2, 100);
    wait_en("t3_gen3", 20);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    wait_idle("t3_idle", 40);
    exp_gc += 3;
    chk("t3_en_n", 64'(en_cnt - e0), 64'd6);
    chk("t3_gd_n", 64'(gd_cnt - g0), 64'd3);
    chk("t3_gc",   64'(gen_count), 64'(exp_gc));
    chk("t3_ngaps", 64'(gaps.size()), 64'd3);
    if (gaps.size() == 3) begin
      chk("t3_gap1", 64'(gaps[1]), 64'd3);
      chk("t3_gap2", 64'(gaps[2]), 64'd3);
    end

    // frame sync: pending pulse, explicit sync, dropped extra pulse
    for (int g = 0; g < 4; g++) begin
      push(0, 16'hA001); push(1, 16'hA002);
    end
    gaps.delete();
    e0 = en_cnt; g0 = gd_cnt;
    sync_enable = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_en("t4_gen1", 20);
    frame_sync = 1'b1;
    @(negedge clk);
    frame_sync = 1'b0;
    wait_gd("t4_gd2", g0 + 2, 100);
    repeat (6) @(negedge clk);
    chk("t4_waiting", 64'({busy, execution_enable}), 64'b10);
    chk("t4_en_hold", 64'(en_cnt - e0), 64'd4);
    frame_sync = 1'b1;
    @(negedge clk);
    frame_sync = 1'b0;
    chk("t4_lat1", 64'(execution_enable), 64'd0);
    @(negedge clk);
    chk("t4_lat2", 64'(execution_enable), 64'd0);
    @(negedge clk);
    chk("t4_sync_pc0", 64'({execution_enable, program_counter}),
        64'({1'b1, 12'd0}));
    frame_sync = 1'b1;
    @(negedge clk);
    frame_sync = 1'b0;
    @(negedge clk);
    frame_sync = 1'b1;
    @(negedge clk);
    frame_sync = 1'b0;
    wait_gd("t4_gd4", g0 + 4, 100);
    repeat (8) @(negedge clk);
    chk("t4_en_n", 64'(en_cnt - e0), 64'd8);
    chk("t4_gd_n", 64'(gd_cnt - g0), 64'd4);
    chk("t4_parked", 64'(busy), 64'd1);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("t4_stop_idle", 64'(busy), 64'd0);
    exp_gc += 4;
    chk("t4_gc", 64'(gen_count), 64'(exp_gc));
    chk("t4_ngaps", 64'(gaps.size()), 64'd4);
    if (gaps.size() == 4) begin
      chk("t4_gap_pend1", 64'(gaps[1]), 64'd4);
      chk("t4_gap_pend3", 64'(gaps[3]), 64'd4);
    end
    sync_enable = 1'b0;

    // full memory without END
    for (int i = 0; i < (1 << PCW); i++) begin
      wr(i, {4'(i % 15), 12'(i)});
      push(i, {4'(i % 15), 12'(i)});
    end
    e0 = en_cnt; g0 = gd_cnt;
    pulse_step();
    wait_idle("t5_idle", 4300);
    exp_gc++;
    chk("t5_en_n", 64'(en_cnt - e0), 64'(1 << PCW));
    chk("t5_gd_n", 64'(gd_cnt - g0), 64'd1);
    chk("t5_pc_hold", 64'(program_counter), 64'hFFF);
    chk("t5_instr", 64'(instruction), 64'({4'(4095 % 15), 12'hFFF}));
    chk("t5_gc", 64'(gen_count), 64'(exp_gc));

    // reset mid-EXEC at pc=5
    for (int i = 0; i < 10; i++) wr(i, 16'hB000 + 16'(i));
    wr(10, 16'hF000);
    for (int i = 0; i < 6; i++) push(i, 16'hB000 + 16'(i));
    pulse_step();
    n = 0;
    while (!(execution_enable && program_counter == 12'd5) && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("t6_reach_pc5", 64'(program_counter), 64'd5);
    #1 rst = 1'b1;
    #1;
    chk("t6_rst_en",   64'(execution_enable), 64'd0);
    chk("t6_rst_pc",   64'(program_counter),  64'd0);
    chk("t6_rst_ins",  64'(instruction),      64'd0);
    chk("t6_rst_busy", 64'(busy),             64'd0);
    chk("t6_rst_gc",   64'(gen_count),        64'd0);
    chk("t6_sb",       64'(sb.size()),        64'd0);
    sb.delete();
    exp_gc = 0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // write while busy must not land; RAM survives reset
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 10; i++) push(i, 16'hB000 + 16'(i));
      e0 = en_cnt;
      pulse_step();
      if (r == 0) begin
        prog_we    = 1'b1;
        prog_addr  = 12'd2;
        prog_wdata = 16'hDEAD;
        repeat (3) @(negedge clk);
        prog_we    = 1'b0;
      end
      wait_idle("t6_idle", 40);
      exp_gc++;
      chk("t6_en_n", 64'(en_cnt - e0), 64'd10);
      chk("t6_gc", 64'(gen_count), 64'(exp_gc));
    end
    chk("t6_sb_end", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
